// File: rtl/serial_cpu_pkg.sv
// Shared opcode, FSM state and width definitions for the bit-serial datapath.
package serial_cpu_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_MOV = 3'b101,
    OP_CMP = 3'b110,
    OP_NOP = 3'b111
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic op_is_arith(op_t o);
    return (o == OP_ADD) || (o == OP_SUB) || (o == OP_CMP);
  endfunction

  function automatic logic op_inverts_b(op_t o);
    return (o == OP_SUB) || (o == OP_CMP);
  endfunction

  function automatic logic op_writes(op_t o);
    return (o != OP_CMP) && (o != OP_NOP);
  endfunction

endpackage

// File: rtl/serial_fa.sv
// 1-bit combinational full adder; zero latency, no flow control.
module serial_fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_alu.sv
// Bit-serial ALU, LSB first: DATA_WIDTH RUN cycles plus one DONE cycle per op;
// result bits are combinational in RUN, and start is ignored (not queued) while busy.
module serial_alu
  import serial_cpu_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic                  use_imm,
  input  logic [DATA_WIDTH-1:0] imm,
  input  logic                  rs1_bit,
  input  logic                  rs2_bit,
  output logic                  wr_bit,
  output logic                  wr_en,
  output logic                  shift_en,
  output logic                  busy,
  output logic                  done,
  output logic                  flag_c,
  output logic                  flag_z
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  state_t                state, state_nxt;
  logic [CW-1:0]         cnt;
  logic                  carry;
  logic [DATA_WIDTH-1:0] imm_sr;
  op_t                   op_q;
  logic                  use_imm_q;
  logic                  zero_q;

  logic run, last;
  logic b_bit, fa_b, fa_sum, fa_cout, res_bit;

  assign b_bit = use_imm_q ? imm_sr[0] : rs2_bit;
  // SUB/CMP add the inverted operand with carry-in preset to 1 (two's complement).
  assign fa_b  = b_bit ^ op_inverts_b(op_q);
  assign last  = (cnt == CW'(DATA_WIDTH - 1));

  serial_fa u_fa (
    .a    (rs1_bit),
    .b    (fa_b),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  always_comb begin
    res_bit = 1'b0;
    case (op_q)
      OP_ADD, OP_SUB, OP_CMP: res_bit = fa_sum;
      OP_AND:                 res_bit = rs1_bit & b_bit;
      OP_OR:                  res_bit = rs1_bit | b_bit;
      OP_XOR:                 res_bit = rs1_bit ^ b_bit;
      OP_MOV:                 res_bit = b_bit;
      default:                res_bit = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    run       = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_RUN;
      ST_RUN: begin
        run  = 1'b1;
        busy = 1'b1;
        if (last) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign wr_bit   = run & res_bit;
  assign wr_en    = run & op_writes(op_q);
  assign shift_en = run & ~op_writes(op_q);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      carry     <= 1'b0;
      imm_sr    <= '0;
      op_q      <= OP_ADD;
      use_imm_q <= 1'b0;
      zero_q    <= 1'b1;
      flag_c    <= 1'b0;
      flag_z    <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          if (start) begin
            op_q      <= op_t'(op);
            use_imm_q <= use_imm;
            imm_sr    <= imm;
            cnt       <= '0;
            carry     <= op_inverts_b(op_t'(op));
            zero_q    <= 1'b1;
          end
        end
        ST_RUN: begin
          cnt    <= cnt + CW'(1);
          imm_sr <= imm_sr >> 1;
          if (op_is_arith(op_q)) carry <= fa_cout;
          if (res_bit) zero_q <= 1'b0;
          // Flags take the final bit into account on the RUN->DONE edge.
          if (last) begin
            if (op_q != OP_NOP)    flag_z <= zero_q & ~res_bit;
            if (op_is_arith(op_q)) flag_c <= fa_cout;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_alu.sv
// Directed bench for serial_alu with a bit-addressed register file model and a reference model.
module tb_serial_alu;

  localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010, OR_ = 3'b011,
                         XOR_ = 3'b100, MOV = 3'b101, CMP = 3'b110, NOP = 3'b111;

  logic       clk, rstn, start, use_imm, rs1_bit, rs2_bit;
  logic [2:0] op;
  logic [7:0] imm;
  logic       wr_bit, wr_en, shift_en, busy, done, flag_c, flag_z;

  int tests = 0;
  int fails = 0;

  logic [7:0] tb_a, tb_b, dest;
  logic [2:0] idx;
  int         wr_cnt = 0, sh_cnt = 0, done_cnt = 0;

  // Reference model state
  int         m_phase;
  logic [2:0] m_op;
  logic [7:0] m_res;
  logic       m_c, m_fc, m_fz;

  serial_alu #(.DATA_WIDTH(8)) dut (
    .clk(clk), .rstn(rstn), .start(start), .op(op), .use_imm(use_imm), .imm(imm),
    .rs1_bit(rs1_bit), .rs2_bit(rs2_bit), .wr_bit(wr_bit), .wr_en(wr_en),
    .shift_en(shift_en), .busy(busy), .done(done), .flag_c(flag_c), .flag_z(flag_z)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_res(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
    case (o)
      ADD:      return a + b;
      SUB, CMP: return a - b;
      AND_:     return a & b;
      OR_:      return a | b;
      XOR_:     return a ^ b;
      MOV:      return b;
      default:  return 8'h00;
    endcase
  endfunction

  function automatic logic model_carry(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (o == ADD) return s[8];
    return a >= b;
  endfunction

  // Register file: one read/write bit index advancing on wr_en or shift_en.
  assign rs1_bit = tb_a[idx];
  assign rs2_bit = tb_b[idx];

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      idx <= 3'd0;
    end else begin
      if (wr_en) begin
        dest[idx] <= wr_bit;
        wr_cnt    <= wr_cnt + 1;
      end
      if (shift_en) sh_cnt <= sh_cnt + 1;
      if (wr_en || shift_en) idx <= idx + 3'd1;
      if (done) done_cnt <= done_cnt + 1;
    end
  end

  // Reference model: phase -1 idle, 0..7 bit cycles, 8 completion cycle.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_phase <= -1;
      m_op    <= ADD;
      m_res   <= 8'h00;
      m_c     <= 1'b0;
      m_fc    <= 1'b0;
      m_fz    <= 1'b0;
    end else if (m_phase == -1) begin
      if (start) begin
        m_op    <= op;
        m_res   <= model_res(op, tb_a, use_imm ? imm : tb_b);
        m_c     <= model_carry(op, tb_a, use_imm ? imm : tb_b);
        m_phase <= 0;
      end
    end else if (m_phase < 7) begin
      m_phase <= m_phase + 1;
    end else if (m_phase == 7) begin
      m_phase <= 8;
      if (m_op != NOP) m_fz <= (m_res == 8'h00);
      if (m_op == ADD || m_op == SUB || m_op == CMP) m_fc <= m_c;
    end else begin
      m_phase <= -1;
    end
  end

  always @(negedge clk) begin
    if (rstn) begin
      logic run, writes;
      run    = (m_phase >= 0) && (m_phase <= 7);
      writes = (m_op != CMP) && (m_op != NOP);
      check("busy", busy, m_phase >= 0);
      check("done", done, m_phase == 8);
      check("wr_en", wr_en, run && writes);
      check("shift_en", shift_en, run && !writes);
      if (!run) check("wr_bit_idle", wr_bit, 1'b0);
      else if (writes) check("wr_bit", wr_bit, m_res[m_phase[2:0]]);
      check("flag_c", flag_c, m_fc);
      check("flag_z", flag_z, m_fz);
    end
  end

  task automatic run_op(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                        input logic ui, input logic [7:0] im, input logic hold,
                        input logic [7:0] exp_dest, input int exp_wr, input int exp_sh,
                        input logic exp_c, input logic exp_z);
    int  wr0, sh0, dn0, n;
    bit  got;
    wr0 = wr_cnt; sh0 = sh_cnt; dn0 = done_cnt;
    tb_a = a; tb_b = b; op = o; use_imm = ui; imm = im;
    start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    got = 0; n = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      n++;
      if (done) got = 1;
    end
    check("done_seen", got, 1'b1);
    check("done_latency", n, 9);
    check("flag_c_lit", flag_c, exp_c);
    check("flag_z_lit", flag_z, exp_z);
    @(posedge clk); #1;
    start = 1'b0;
    check("dest_lit", dest, exp_dest);
    check("wr_en_cycles", wr_cnt - wr0, exp_wr);
    check("shift_en_cycles", sh_cnt - sh0, exp_sh);
    check("done_pulses", done_cnt - dn0, 1);
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; op = ADD; use_imm = 1'b0; imm = 8'h00;
    tb_a = 8'h00; tb_b = 8'h00; dest = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_wr_bit", wr_bit, 1'b0);
    check("rst_wr_en", wr_en, 1'b0);
    check("rst_shift_en", shift_en, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_flag_c", flag_c, 1'b0);
    check("rst_flag_z", flag_z, 1'b0);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;

    //     op    A      B      imm   val    hold  dest   wr sh C     Z
    run_op(ADD,  8'h5A, 8'h3C, 1'b0, 8'h00, 1'b0, 8'h96, 8, 0, 1'b0, 1'b0);
    run_op(ADD,  8'hFF, 8'hAA, 1'b1, 8'h01, 1'b0, 8'h00, 8, 0, 1'b1, 1'b1);
    run_op(SUB,  8'h10, 8'h10, 1'b0, 8'h00, 1'b0, 8'h00, 8, 0, 1'b1, 1'b1);
    run_op(SUB,  8'h03, 8'h05, 1'b0, 8'h00, 1'b0, 8'hFE, 8, 0, 1'b0, 1'b0);
    run_op(CMP,  8'h07, 8'h07, 1'b0, 8'h00, 1'b0, 8'hFE, 0, 8, 1'b1, 1'b1);
    run_op(AND_, 8'hF0, 8'h0F, 1'b0, 8'h00, 1'b0, 8'h00, 8, 0, 1'b1, 1'b1);
    run_op(OR_,  8'hA0, 8'hFF, 1'b1, 8'h05, 1'b0, 8'hA5, 8, 0, 1'b1, 1'b0);
    run_op(XOR_, 8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 8'h00, 8, 0, 1'b1, 1'b1);
    run_op(MOV,  8'h33, 8'h80, 1'b0, 8'h00, 1'b0, 8'h80, 8, 0, 1'b1, 1'b0);
    run_op(NOP,  8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 8'h80, 0, 8, 1'b1, 1'b0);
    run_op(ADD,  8'h01, 8'h02, 1'b0, 8'h00, 1'b1, 8'h03, 8, 0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1 check("idle_after_hold", busy, 1'b0);

    // Asynchronous reset in the middle of an ADD.
    tb_a = 8'h5A; tb_b = 8'h3C; op = ADD; use_imm = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    check("mid_rst_wr_bit", wr_bit, 1'b0);
    check("mid_rst_wr_en", wr_en, 1'b0);
    check("mid_rst_shift_en", shift_en, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_done", done, 1'b0);
    check("mid_rst_flag_c", flag_c, 1'b0);
    check("mid_rst_flag_z", flag_z, 1'b0);
    #1 rstn = 1'b1;
    @(posedge clk); #1;
    check("post_rst_busy", busy, 1'b0);
    check("post_rst_done", done, 1'b0);
    run_op(ADD,  8'h5A, 8'h3C, 1'b0, 8'h00, 1'b0, 8'h96, 8, 0, 1'b0, 1'b0);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
